// File: rtl/masked_rr_arbiter.sv
// Round-robin arbiter that hands one shared resource to one lane at a time.
// Only lanes below SIZE whose MASK bit is set can be granted. Requests on any
// other lane are ignored for arbitration and only raise req_err. HOLD_MAX
// optionally limits how long one owner may hold the grant. The timeout output
// pulses for one cycle when that limit takes the grant away.
//
//  state | meaning
//  ------+-----------------------------------------------------------------
//  IDLE  | no owner; grant the first eligible lane after ptr on next edge
//  GRANT | gnt_id owns the resource; hold, or release and hand over directly
module masked_rr_arbiter #(
    parameter int                  MAX_SIZE = 4,
    parameter int                  SIZE     = 4,
    parameter logic [MAX_SIZE-1:0] MASK     = {MAX_SIZE{1'b1}},
    parameter int                  HOLD_MAX = 0,
    parameter int                  ID_W     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [MAX_SIZE-1:0] req,
    output logic [MAX_SIZE-1:0] gnt,
    output logic [ID_W-1:0]     gnt_id,
    output logic                gnt_valid,
    output logic                timeout,
    output logic                req_err
);

    // hold_cnt only has to reach HOLD_MAX-1; at least one bit is always kept
    localparam int CNT_W    = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
    localparam int HOLD_LIM = (HOLD_MAX > 0) ? HOLD_MAX - 1 : 0;
    localparam logic [ID_W-1:0] PTR_RST = ID_W'(MAX_SIZE - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     ptr_nxt;
    logic [CNT_W-1:0]    hold_cnt;
    logic [CNT_W-1:0]    hold_cnt_nxt;
    logic [MAX_SIZE-1:0] gnt_nxt;
    logic [ID_W-1:0]     gnt_id_nxt;
    logic                gnt_valid_nxt;
    logic                timeout_nxt;

    logic [MAX_SIZE-1:0] lane_en;
    logic [MAX_SIZE-1:0] elig;
    logic [MAX_SIZE-1:0] srch_cand;
    logic [ID_W-1:0]     srch_base;
    logic [ID_W-1:0]     cand_idx;
    logic [ID_W-1:0]     srch_idx;
    logic                srch_found;
    logic                owner_elig;
    logic                hold_hit;
    logic                release_now;

    // Unused lanes are tied off without ever looking at their MASK bit
    for (genvar g = 0; g < MAX_SIZE; g++) begin : g_lane
        if (g < SIZE) begin : g_used
            assign lane_en[g] = MASK[g];
        end else begin : g_unused
            assign lane_en[g] = 1'b0;
        end
    end

    assign elig    = req & lane_en;
    assign req_err = |(req & ~lane_en);

    assign owner_elig  = elig[gnt_id];
    assign hold_hit    = (HOLD_MAX != 0) && (hold_cnt == CNT_W'(HOLD_LIM));
    assign release_now = !owner_elig || hold_hit;

    // While granting, the search starts after the owner and leaves the owner
    // out, so a release hands over to another lane with no bubble.
    assign srch_cand = (state == GRANT) ? (elig & ~gnt) : elig;
    assign srch_base = (state == GRANT) ? gnt_id : ptr;

    // Rotating priority search: first candidate after srch_base, wrapping
    always_comb begin
        srch_found = 1'b0;
        srch_idx   = '0;
        cand_idx   = '0;
        for (int k = 1; k <= MAX_SIZE; k++) begin
            cand_idx = ID_W'((int'(srch_base) + k) % MAX_SIZE);
            if (!srch_found && srch_cand[cand_idx]) begin
                srch_found = 1'b1;
                srch_idx   = cand_idx;
            end
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        hold_cnt_nxt  = hold_cnt;
        gnt_nxt       = gnt;
        gnt_id_nxt    = gnt_id;
        gnt_valid_nxt = gnt_valid;
        timeout_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (srch_found) begin
                    state_nxt     = GRANT;
                    gnt_nxt       = MAX_SIZE'(1) << srch_idx;
                    gnt_id_nxt    = srch_idx;
                    gnt_valid_nxt = 1'b1;
                    hold_cnt_nxt  = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_nxt = gnt_id;
                    // A pulse only when the limit took the grant from a lane
                    // that still wanted it
                    timeout_nxt = hold_hit && owner_elig;
                    if (srch_found) begin
                        gnt_nxt       = MAX_SIZE'(1) << srch_idx;
                        gnt_id_nxt    = srch_idx;
                        gnt_valid_nxt = 1'b1;
                        hold_cnt_nxt  = '0;
                    end else begin
                        state_nxt     = IDLE;
                        gnt_nxt       = '0;
                        gnt_valid_nxt = 1'b0;
                    end
                end else if (hold_cnt != {CNT_W{1'b1}}) begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt     = IDLE;
                gnt_nxt       = '0;
                gnt_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset hands first priority to lane 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= PTR_RST;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            hold_cnt  <= hold_cnt_nxt;
            gnt       <= gnt_nxt;
            gnt_id    <= gnt_id_nxt;
            gnt_valid <= gnt_valid_nxt;
            timeout   <= timeout_nxt;
        end
    end

`ifndef SYNTHESIS
    // Grant is one-hot or idle, lands only on enabled lanes, and matches valid
    always @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(gnt)) else $error("gnt is not one-hot or zero");
            assert ((gnt & ~lane_en) == '0) else $error("gnt on a disabled lane");
            assert (gnt_valid == (|gnt)) else $error("gnt_valid disagrees with gnt");
        end
    end
`endif

endmodule

// File: tb/tb_masked_rr_arbiter.sv
// Bench for masked_rr_arbiter. Four configurations run side by side, each with
// its own request vector. A lane-level model (owner, tenure length, last owner)
// predicts every output each cycle. Directed sequences pin that model with
// hand-worked grant orders, and random traffic then exercises it further.
module tb_masked_rr_arbiter;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req       [N];
    logic [3:0] gnt       [N];
    logic [1:0] gnt_id    [N];
    logic       gnt_valid [N];
    logic       timeout   [N];
    logic       req_err   [N];

    int n_cmp = 0;
    int n_bad = 0;

    // model state per instance: owner lane (-1 none), cycles granted, last owner
    int m_own  [N];
    int m_ten  [N];
    int m_last [N];
    bit m_tmo  [N];

    always #5 clk = ~clk;

    masked_rr_arbiter #(.MAX_SIZE(4), .SIZE(2), .MASK(4'b0011), .HOLD_MAX(0), .ID_W(2)) u_a (
        .clk(clk), .rst(rst), .req(req[0]), .gnt(gnt[0]), .gnt_id(gnt_id[0]),
        .gnt_valid(gnt_valid[0]), .timeout(timeout[0]), .req_err(req_err[0]));
    masked_rr_arbiter #(.MAX_SIZE(4), .SIZE(4), .MASK(4'b1111), .HOLD_MAX(0), .ID_W(2)) u_b (
        .clk(clk), .rst(rst), .req(req[1]), .gnt(gnt[1]), .gnt_id(gnt_id[1]),
        .gnt_valid(gnt_valid[1]), .timeout(timeout[1]), .req_err(req_err[1]));
    masked_rr_arbiter #(.MAX_SIZE(4), .SIZE(4), .MASK(4'b0101), .HOLD_MAX(0), .ID_W(2)) u_c (
        .clk(clk), .rst(rst), .req(req[2]), .gnt(gnt[2]), .gnt_id(gnt_id[2]),
        .gnt_valid(gnt_valid[2]), .timeout(timeout[2]), .req_err(req_err[2]));
    masked_rr_arbiter #(.MAX_SIZE(4), .SIZE(4), .MASK(4'b1111), .HOLD_MAX(3), .ID_W(2)) u_d (
        .clk(clk), .rst(rst), .req(req[3]), .gnt(gnt[3]), .gnt_id(gnt_id[3]),
        .gnt_valid(gnt_valid[3]), .timeout(timeout[3]), .req_err(req_err[3]));

    function automatic int size_of(input int i);
        return (i == 0) ? 2 : 4;
    endfunction

    function automatic logic [3:0] mask_of(input int i);
        case (i)
            0:       return 4'b0011;
            2:       return 4'b0101;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic int hold_of(input int i);
        return (i == 3) ? 3 : 0;
    endfunction

    function automatic bit lane_ok(input int i, input int l);
        logic [3:0] m;
        m = mask_of(i);
        return (l < size_of(i)) && (m[l] == 1'b1);
    endfunction

    function automatic bit elig(input int i, input int l);
        return (req[i][l] == 1'b1) && lane_ok(i, l);
    endfunction

    // first eligible lane after 'after', wrapping, never 'skip'
    function automatic int pick(input int i, input int after, input int skip);
        for (int k = 1; k <= 4; k++) begin
            int l;
            l = (after + k) % 4;
            if (l != skip && elig(i, l)) return l;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_own[i]  = -1;
            m_ten[i]  = 0;
            m_last[i] = 3;
            m_tmo[i]  = 1'b0;
        end
    endtask

    task automatic model_step(input int i);
        bit forced;
        m_tmo[i] = 1'b0;
        if (m_own[i] < 0) begin
            m_own[i] = pick(i, m_last[i], -1);
            m_ten[i] = 1;
        end else begin
            forced = (hold_of(i) != 0) && (m_ten[i] >= hold_of(i));
            if (!elig(i, m_own[i]) || forced) begin
                m_tmo[i]  = forced && elig(i, m_own[i]);
                m_last[i] = m_own[i];
                m_own[i]  = pick(i, m_last[i], m_last[i]);
                m_ten[i]  = 1;
            end else begin
                m_ten[i] = m_ten[i] + 1;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // model advances on the same edges as the DUT
    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else for (int i = 0; i < N; i++) model_step(i);
        end
    end

    // compare every instance against the model on every falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int i = 0; i < N; i++) begin
                    int  eg;
                    bit  ee;
                    eg = (m_own[i] < 0) ? 0 : (1 << m_own[i]);
                    ee = 1'b0;
                    for (int l = 0; l < 4; l++) if (req[i][l] && !lane_ok(i, l)) ee = 1'b1;
                    chk($sformatf("m_gnt[%0d]", i), int'(gnt[i]), eg);
                    chk($sformatf("m_valid[%0d]", i), int'(gnt_valid[i]), (m_own[i] >= 0) ? 1 : 0);
                    chk($sformatf("m_timeout[%0d]", i), int'(timeout[i]), int'(m_tmo[i]));
                    chk($sformatf("m_req_err[%0d]", i), int'(req_err[i]), int'(ee));
                    if (m_own[i] >= 0)
                        chk($sformatf("m_gnt_id[%0d]", i), int'(gnt_id[i]), m_own[i]);
                end
            end
        end
    end

    initial begin
        int ea [5] = '{0, 1, 0, 1, 0};
        int eb [5] = '{0, 1, 2, 3, 0};
        int ec [5] = '{0, 2, 0, 2, 0};
        int ed [5] = '{4, 4, 4, 0, 4};
        int et [5] = '{0, 0, 0, 1, 0};

        rst = 1'b1;
        for (int i = 0; i < N; i++) req[i] = 4'b0000;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // no requests: everything stays quiet
        repeat (10) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                chk($sformatf("idle_gnt[%0d]", i), int'(gnt[i]), 0);
                chk($sformatf("idle_valid[%0d]", i), int'(gnt_valid[i]), 0);
                chk($sformatf("idle_timeout[%0d]", i), int'(timeout[i]), 0);
            end
        end

        // owners drop their request the cycle after grant; lane 2 held on u_d
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) req[i] = 4'b1111;
        req[3] = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("seq_a_id[%0d]", k), int'(gnt_id[0]), ea[k]);
            chk($sformatf("seq_b_id[%0d]", k), int'(gnt_id[1]), eb[k]);
            chk($sformatf("seq_c_id[%0d]", k), int'(gnt_id[2]), ec[k]);
            chk($sformatf("seq_b_valid[%0d]", k), int'(gnt_valid[1]), 1);
            chk($sformatf("seq_a_hi_lanes[%0d]", k), int'(gnt[0][3:2]), 0);
            chk($sformatf("seq_a_req_err[%0d]", k), int'(req_err[0]), 1);
            chk($sformatf("seq_c_req_err[%0d]", k), int'(req_err[2]), 1);
            chk($sformatf("seq_d_gnt[%0d]", k), int'(gnt[3]), ed[k]);
            chk($sformatf("seq_d_timeout[%0d]", k), int'(timeout[3]), et[k]);
            for (int i = 0; i < 3; i++) req[i] = 4'b1111 & ~gnt[i];
        end

        // grant lane 3, then reset between edges
        rst = 1'b1;
        for (int i = 0; i < N; i++) req[i] = 4'b0000;
        req[1] = 4'b1000;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_pre_gnt", int'(gnt[1]), 8);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_gnt", int'(gnt[1]), 0);
        chk("rst_async_valid", int'(gnt_valid[1]), 0);
        @(posedge clk);
        #1;
        chk("rst_held_gnt", int'(gnt[1]), 0);
        req[1] = 4'b1001;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_after_id", int'(gnt_id[1]), 0);
        chk("rst_after_gnt", int'(gnt[1]), 1);

        // random traffic, each request bit toggling with probability 1/4
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if (c == 1500) rst = 1'b1;
            if (c == 1502) rst = 1'b0;
            for (int i = 0; i < N; i++)
                for (int l = 0; l < 4; l++)
                    if ($urandom_range(0, 3) == 0) req[i][l] = ~req[i][l];
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
